// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: records first hit of each toggle cover point and queues its global index
// Ports:
//   clock, reset (sync, active-low)    - clocking and reset
//   valid[WIDTH]                       - per-point toggle events
//   clear_hits                         - clears bitmap, pending set and hit_count (queue kept)
//   out_valid/out_ready/out_index      - newly covered global index stream
//   out_cycle (COVER_COLLECT_TIMESTAMP_EN only) - cycle counter value at the recording edge
//   hit_count, all_covered             - number of distinct points covered, all points covered
// Optional feature macro: COVER_COLLECT_TIMESTAMP_EN
module cover_toggle_collector #(
    parameter int          WIDTH       = 5,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             valid,
    input  logic                         clear_hits,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_index,
`ifdef COVER_COLLECT_TIMESTAMP_EN
    output logic [31:0]                  out_cycle,
`endif
    output logic [$clog2(WIDTH+1)-1:0]   hit_count,
    output logic                         all_covered
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] hit, pending, new_hits, sel_mask;
    logic [IW-1:0]    sel;
    logic [CW-1:0]    count, new_count;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [IW-1:0]    idx_mem [FIFO_DEPTH];
    logic             full, push, pop;

    always_comb begin
        new_hits  = valid & ~hit;
        sel       = '0;
        new_count = '0;
        // descending scan leaves the lowest pending index selected
        for (int i = WIDTH - 1; i >= 0; i--)
            if (pending[i]) sel = IW'(i);
        for (int i = 0; i < WIDTH; i++)
            new_count = new_count + CW'(new_hits[i]);
        sel_mask = WIDTH'(1) << sel;
    end

    assign out_valid   = wr_ptr != rd_ptr;
    assign full        = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pop         = out_valid & out_ready;
    // a pop in the same edge frees the slot, so a full queue can still accept
    assign push        = |pending & (~full | pop) & ~clear_hits;
    assign out_index   = out_valid ? COVER_INDEX + 64'(idx_mem[rd_ptr[AW-1:0]]) : 64'd0;
    assign hit_count   = count;
    assign all_covered = count == CW'(WIDTH);

    always_ff @(posedge clock) begin
        if (!reset) begin
            hit     <= '0;
            pending <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (clear_hits) begin
                hit     <= '0;
                pending <= '0;
                count   <= '0;
            end else begin
                hit     <= hit | new_hits;
                pending <= (pending & ~(push ? sel_mask : '0)) | new_hits;
                count   <= count + new_count;
            end
        end
    end

    // queue stores only the local point number; the global offset is added at the head
    always_ff @(posedge clock)
        if (reset && push) idx_mem[wr_ptr[AW-1:0]] <= sel;

`ifdef COVER_COLLECT_TIMESTAMP_EN
    logic [31:0] cycle;
    logic [31:0] stamp   [WIDTH];
    logic [31:0] cyc_mem [FIFO_DEPTH];

    assign out_cycle = out_valid ? cyc_mem[rd_ptr[AW-1:0]] : 32'd0;

    always_ff @(posedge clock) begin
        if (!reset) cycle <= '0;
        else cycle <= cycle + 32'd1;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++)
            if (reset && !clear_hits && new_hits[i]) stamp[i] <= cycle;
        if (reset && push) cyc_mem[wr_ptr[AW-1:0]] <= stamp[sel];
    end
`endif
endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: directed plus random checks of cover_toggle_collector against a queue model
module tb_cover_toggle_collector;
    localparam int          W  = 5;
    localparam int          D  = 4;
    localparam logic [63:0] CI = 64'd100;

    logic          clock = 0, reset = 0, clear_hits = 0, out_ready = 0;
    logic [W-1:0]  valid = '0;
    logic          out_valid, all_covered;
    logic [63:0]   out_index;
    logic [2:0]    hit_count;
`ifdef COVER_COLLECT_TIMESTAMP_EN
    logic [31:0]   out_cycle;
`endif

    cover_toggle_collector #(.WIDTH(W), .COVER_INDEX(CI), .FIFO_DEPTH(D)) dut (
        .clock(clock), .reset(reset), .valid(valid), .clear_hits(clear_hits),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
`ifdef COVER_COLLECT_TIMESTAMP_EN
        .out_cycle(out_cycle),
`endif
        .hit_count(hit_count), .all_covered(all_covered));

    always #5 clock = ~clock;

    bit [W-1:0]   m_hit, m_pend;
    int           m_cnt;
    int unsigned  m_cyc;
    int unsigned  m_stamp [W];
    logic [63:0]  q_idx[$];
    int unsigned  q_cyc[$];
    int           n_vec = 0, n_err = 0;

    // behavioural model: set-of-covered-points plus an ordered delivery queue
    task automatic model_edge();
        int lo;
        bit do_pop, do_push;
        if (!reset) begin
            m_hit = '0; m_pend = '0; m_cnt = 0; m_cyc = 0;
            q_idx.delete(); q_cyc.delete();
            return;
        end
        lo = -1;
        for (int i = W - 1; i >= 0; i--) if (m_pend[i]) lo = i;
        do_pop  = q_idx.size() > 0 && out_ready;
        do_push = !clear_hits && lo >= 0 && (q_idx.size() < D || do_pop);
        if (do_pop) begin
            q_idx.delete(0);
            q_cyc.delete(0);
        end
        if (do_push) begin
            q_idx.push_back(CI + 64'(lo));
            q_cyc.push_back(m_stamp[lo]);
            m_pend[lo] = 1'b0;
        end
        if (clear_hits) begin
            m_hit = '0; m_pend = '0; m_cnt = 0;
        end else begin
            for (int i = 0; i < W; i++)
                if (valid[i] && !m_hit[i]) begin
                    m_hit[i] = 1'b1; m_pend[i] = 1'b1; m_cnt++; m_stamp[i] = m_cyc;
                end
        end
        m_cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit [W-1:0] v, input bit c, input bit rd);
        reset = r; valid = v; clear_hits = c; out_ready = rd;
        @(posedge clock);
        model_edge();
        #1;
        chk("out_valid", 64'(out_valid), 64'(q_idx.size() > 0));
        chk("out_index", out_index, q_idx.size() > 0 ? q_idx[0] : 64'd0);
        chk("hit_count", 64'(hit_count), 64'(m_cnt));
        chk("all_covered", 64'(all_covered), 64'(m_cnt == W));
`ifdef COVER_COLLECT_TIMESTAMP_EN
        chk("out_cycle", 64'(out_cycle), 64'(q_cyc.size() > 0 ? q_cyc[0] : 0));
`endif
    endtask

    initial begin
        repeat (3) step(0, 5'b11111, 0, 0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(hit_count), 64'd0);
        step(1, 5'b00000, 0, 0);
        // single hit
        step(1, 5'b00100, 0, 1);
        chk("single_cnt", 64'(hit_count), 64'd1);
        step(1, 5'b00000, 0, 1);
        chk("single_idx", out_index, 64'd102);
        step(1, 5'b00000, 0, 1);
        step(1, 5'b00100, 0, 1);
        repeat (3) step(1, 5'b00000, 0, 1);
        chk("repulse_none", 64'(out_valid), 64'd0);
        // burst ordering with stall
        step(1, 5'b00000, 1, 0);
        step(1, 5'b11111, 0, 0);
        repeat (6) step(1, 5'b00000, 0, 0);
        chk("burst_head", out_index, 64'd100);
        chk("burst_all", 64'(all_covered), 64'd1);
        step(1, 5'b00000, 0, 1);
        // backpressure hold on 101
        repeat (10) begin
            step(1, 5'b00000, 0, 0);
            chk("hold_idx", out_index, 64'd101);
        end
        step(1, 5'b00000, 0, 1);
        chk("one_pop", out_index, 64'd102);
        repeat (4) step(1, 5'b00000, 0, 1);
        chk("drained", 64'(out_valid), 64'd0);
        // clear collision
        step(1, 5'b00001, 1, 0);
        chk("clr_cnt", 64'(hit_count), 64'd0);
        step(1, 5'b00001, 0, 0);
        chk("reclr_cnt", 64'(hit_count), 64'd1);
        step(1, 5'b00000, 0, 0);
        chk("rereport", out_index, 64'd100);
        step(1, 5'b00000, 0, 1);
        // reset mid-drain
        step(1, 5'b00111, 1, 0);
        step(1, 5'b00111, 0, 0);
        repeat (3) step(1, 5'b00000, 0, 0);
        step(0, 5'b00000, 0, 0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        repeat (3) step(1, 5'b00000, 0, 1);
        chk("no_stale", 64'(out_valid), 64'd0);
        // timestamp at counter value 7
        step(0, 5'b00000, 0, 0);
        repeat (7) step(1, 5'b00000, 0, 0);
        step(1, 5'b00010, 0, 0);
        step(1, 5'b00000, 0, 0);
        chk("ts_idx", out_index, 64'd101);
`ifdef COVER_COLLECT_TIMESTAMP_EN
        chk("ts_cycle", 64'(out_cycle), 64'd7);
`endif
        // randomized traffic
        for (int n = 0; n < 600; n++)
            step($urandom_range(0, 99) != 0, W'($urandom & $urandom & $urandom),
                 $urandom_range(0, 29) == 0, 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
